llc_req_decoder: RTL and testbench

LLC_REQ_DECODER -- requirements
Module: llc_req_decoder

---
 rtl/llc_req_decoder_pkg.sv | 42 ++++
 rtl/llc_req_decoder_fifo.sv | 66 ++++++
 rtl/llc_req_decoder.sv | 112 +++++++++++
 tb/tb_llc_req_decoder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_req_decoder_pkg.sv
// LLC request definitions: trace op codes, queued request layout and
// small decode helpers shared by the request decoder.
package LLC_defs;

   localparam int unsigned TAG_BITS    = 12;
   localparam int unsigned INDEX       = 14;
   localparam int unsigned BYTE_OFFSET = 6;

   typedef enum logic [3:0] {
      OP_READ      = 4'd0,
      OP_WRITE     = 4'd1,
      OP_IFETCH    = 4'd2,
      OP_SNP_READ  = 4'd3,
      OP_SNP_WRITE = 4'd4,
      OP_SNP_RWIM  = 4'd5,
      OP_SNP_INV   = 4'd6,
      OP_CLEAR     = 4'd8,
      OP_PRINT     = 4'd9
   } op_t;

   typedef struct packed {
      op_t                    op;
      logic [TAG_BITS-1:0]    tag;
      logic [INDEX-1:0]       index;
      logic [BYTE_OFFSET-1:0] offset;
   } req_t;

   // Codes 7 and 10-15 have no operation behind them.
   function automatic logic is_legal(input logic [3:0] cmd);
      return (cmd <= 4'd6) || (cmd == 4'd8) || (cmd == 4'd9);
   endfunction

   function automatic logic is_snoop(input op_t op);
      return (op == OP_SNP_READ) || (op == OP_SNP_WRITE) ||
             (op == OP_SNP_RWIM) || (op == OP_SNP_INV);
   endfunction

   function automatic logic is_cpu(input op_t op);
      return (op == OP_READ) || (op == OP_WRITE) || (op == OP_IFETCH);
   endfunction

endpackage

// File: rtl/llc_req_decoder_fifo.sv
// llc_fifo: generic valid/ready FIFO with registered in_ready and a
// one-cycle write-to-head latency. DEPTH must be a power of two >= 2.
module llc_fifo #(
   parameter int unsigned WIDTH = 36,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_nxt;
   logic             push;
   logic             pop;

   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];
   assign occupancy = count;

   // Occupancy after the coming edge; drives the registered ready.
   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   // Pointers, count and ready; ready looks at post-edge occupancy so a
   // full queue never accepts in the same cycle it pops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         in_ready <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count    <= count_nxt;
         in_ready <= (count_nxt < FULL_CNT);
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

endmodule

// File: rtl/llc_req_decoder.sv
// llc_req_decoder: decodes trace commands into LLC requests and queues
// them for the cache controller. Define LLC_REQ_STATS_EN to build the
// CPU/snoop request counters; otherwise the stat ports tie to zero.
module llc_req_decoder
   import LLC_defs::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [3:0]              in_cmd,
   input  logic [31:0]             in_addr,
   output logic                    out_valid,
   input  logic                    out_ready,
   output op_t                     out_op,
   output logic [TAG_BITS-1:0]     out_tag,
   output logic [INDEX-1:0]        out_index,
   output logic [BYTE_OFFSET-1:0]  out_offset,
   output logic                    out_snoop,
   output logic                    err_cmd,
   output logic [$clog2(DEPTH):0]  occupancy,
   output logic [31:0]             stat_cpu_reqs,
   output logic [31:0]             stat_snoop_reqs
);

   localparam int unsigned RW = $bits(req_t);

   logic          cmd_legal;
   logic          fifo_push;
   req_t          in_entry;
   req_t          head;
   logic [RW-1:0] fifo_rdata;

   assign cmd_legal = is_legal(in_cmd);
   assign fifo_push = in_valid && cmd_legal;

   // Split the byte address; CLEAR/PRINT carry no address.
   always_comb begin
      in_entry.op     = op_t'(in_cmd);
      in_entry.tag    = in_addr[31 -: TAG_BITS];
      in_entry.index  = in_addr[BYTE_OFFSET +: INDEX];
      in_entry.offset = in_addr[BYTE_OFFSET-1:0];
      if ((in_cmd == 4'd8) || (in_cmd == 4'd9)) begin
         in_entry.tag    = '0;
         in_entry.index  = '0;
         in_entry.offset = '0;
      end
   end

   llc_fifo #(
      .WIDTH (RW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (fifo_push),
      .in_ready  (in_ready),
      .in_data   (in_entry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (fifo_rdata),
      .occupancy (occupancy)
   );

   assign head = req_t'(fifo_rdata);

   // Head fields read as zero whenever nothing is presented.
   always_comb begin
      out_op     = OP_READ;
      out_tag    = '0;
      out_index  = '0;
      out_offset = '0;
      out_snoop  = 1'b0;
      if (out_valid) begin
         out_op     = head.op;
         out_tag    = head.tag;
         out_index  = head.index;
         out_offset = head.offset;
         out_snoop  = is_snoop(head.op);
      end
   end

   // Illegal codes are swallowed on transfer and flagged for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_cmd <= 1'b0;
      else        err_cmd <= in_valid && in_ready && !cmd_legal;
   end

`ifdef LLC_REQ_STATS_EN
   logic enq;
   assign enq = in_valid && in_ready && cmd_legal;

   // Saturating counts of enqueued CPU and snoop requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_cpu_reqs   <= '0;
         stat_snoop_reqs <= '0;
      end else begin
         if (enq && is_cpu(in_entry.op) && (stat_cpu_reqs != '1))
            stat_cpu_reqs <= stat_cpu_reqs + 1'b1;
         if (enq && is_snoop(in_entry.op) && (stat_snoop_reqs != '1))
            stat_snoop_reqs <= stat_snoop_reqs + 1'b1;
      end
   end
`else
   assign stat_cpu_reqs   = '0;
   assign stat_snoop_reqs = '0;
`endif

endmodule

// File: tb/tb_llc_req_decoder.sv
// Bench for llc_req_decoder: scenario tasks drive commands and check
// flags inline; a negedge monitor scores head entries and err_cmd.
module tb_llc_req_decoder;

   localparam int DEPTH = 8;

`ifdef LLC_REQ_STATS_EN
   localparam logic [31:0] EXP_CPU   = 32'd3;
   localparam logic [31:0] EXP_SNOOP = 32'd2;
`else
   localparam logic [31:0] EXP_CPU   = 32'd0;
   localparam logic [31:0] EXP_SNOOP = 32'd0;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_cmd;
   logic [31:0] in_addr;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_op;
   logic [11:0] out_tag;
   logic [13:0] out_index;
   logic [5:0]  out_offset;
   logic        out_snoop;
   logic        err_cmd;
   logic [3:0]  occupancy;
   logic [31:0] stat_cpu_reqs;
   logic [31:0] stat_snoop_reqs;

   typedef struct {
      logic [3:0]  op;
      logic [11:0] tag;
      logic [13:0] idx;
      logic [5:0]  off;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic err_exp = 1'b0;
   logic [3:0] legal_cmds [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

   llc_req_decoder #(.DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_cmd          (in_cmd),
      .in_addr         (in_addr),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_op          (out_op),
      .out_tag         (out_tag),
      .out_index       (out_index),
      .out_offset      (out_offset),
      .out_snoop       (out_snoop),
      .err_cmd         (err_cmd),
      .occupancy       (occupancy),
      .stat_cpu_reqs   (stat_cpu_reqs),
      .stat_snoop_reqs (stat_snoop_reqs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mid-cycle monitor: score the head, err_cmd, and record transfers.
   always @(negedge clk) begin
      exp_t e;
      logic lg;
      checks++;
      if (err_cmd !== err_exp) begin
         errors++;
         $display("FAIL err_cmd: got %b expected %b at %0t", err_cmd, err_exp, $time);
      end
      if (out_valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL head_unexpected: got op %0d with empty scoreboard at %0t", out_op, $time);
         end else begin
            e = sb[0];
            if (out_op !== e.op || out_tag !== e.tag || out_index !== e.idx ||
                out_offset !== e.off || out_snoop !== (e.op >= 4'd3 && e.op <= 4'd6)) begin
               errors++;
               $display("FAIL head: got op %0d tag %h idx %h off %h snp %b expected op %0d tag %h idx %h off %h at %0t",
                        out_op, out_tag, out_index, out_offset, out_snoop, e.op, e.tag, e.idx, e.off, $time);
            end
            if (out_ready === 1'b1) void'(sb.pop_front());
         end
      end else begin
         checks++;
         if ({out_op, out_tag, out_index, out_offset, out_snoop} !== 37'd0) begin
            errors++;
            $display("FAIL idle_zero: got op %0d tag %h idx %h off %h snp %b expected all zero at %0t",
                     out_op, out_tag, out_index, out_offset, out_snoop, $time);
         end
      end
      if (rst_n !== 1'b1) begin
         err_exp = 1'b0;
      end else if (in_valid && in_ready) begin
         lg = (in_cmd <= 4'd6) || (in_cmd == 4'd8) || (in_cmd == 4'd9);
         err_exp = !lg;
         if (lg) begin
            e.op = in_cmd;
            if (in_cmd >= 4'd8) begin
               e.tag = '0; e.idx = '0; e.off = '0;
            end else begin
               e.tag = in_addr[31:20]; e.idx = in_addr[19:6]; e.off = in_addr[5:0];
            end
            sb.push_back(e);
         end
      end else begin
         err_exp = 1'b0;
      end
   end

   // Drive one command and hold it until accepted; enter/leave at posedge+1.
   task automatic send(input logic [3:0] cmd, input logic [31:0] addr);
      bit ok = 0;
      in_valid = 1'b1;
      in_cmd   = cmd;
      in_addr  = addr;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_timeout: got in_ready %b expected 1 for cmd %0d", in_ready, cmd);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok = 0;
      for (int t = 0; t < 100; t++) begin
         if (occupancy === 4'd0 && sb.size() == 0) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL drain: got occupancy %0d scoreboard %0d expected 0 0", occupancy, sb.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_cmd = '0; in_addr = '0; out_ready = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || occupancy !== 4'd0 || err_cmd !== 1'b0 ||
          stat_cpu_reqs !== 32'd0 || stat_snoop_reqs !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: got rdy %b vld %b occ %0d err %b cpu %0d snp %0d expected 0 0 0 0 0 0",
                  in_ready, out_valid, occupancy, err_cmd, stat_cpu_reqs, stat_snoop_reqs);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_after_release: got %b expected 0", in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_first_edge: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_basic();
      out_ready = 1'b0;
      send(4'd0, 32'h1234_5678);
      checks++;
      if (out_valid !== 1'b1 || out_op !== 4'd0 || out_tag !== 12'h123 || out_index !== 14'h1159 ||
          out_offset !== 6'h38 || out_snoop !== 1'b0) begin
         errors++;
         $display("FAIL basic_read: got vld %b op %0d tag %h idx %h off %h snp %b expected 1 0 123 1159 38 0",
                  out_valid, out_op, out_tag, out_index, out_offset, out_snoop);
      end
      out_ready = 1'b1;
      wait_drain();
   endtask

   task automatic test_illegal();
      out_ready = 1'b0;
      send(4'd7, 32'hDEAD_BEEF);
      checks++;
      if (err_cmd !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL illegal_err: got err %b vld %b expected 1 0", err_cmd, out_valid);
      end
      send(4'd4, 32'hFFFF_FFC0);
      checks++;
      if (err_cmd !== 1'b0 || occupancy !== 4'd1 || out_op !== 4'd4 || out_snoop !== 1'b1 ||
          out_tag !== 12'hFFF || out_index !== 14'h3FFF || out_offset !== 6'h00) begin
         errors++;
         $display("FAIL illegal_then_snp: got err %b occ %0d op %0d snp %b tag %h idx %h off %h expected 0 1 4 1 fff 3fff 00",
                  err_cmd, occupancy, out_op, out_snoop, out_tag, out_index, out_offset);
      end
      out_ready = 1'b1;
      wait_drain();
   endtask

   task automatic test_full();
      logic [3:0] cmds [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8};
      bit ok = 0;
      out_ready = 1'b0;
      for (int k = 0; k < 8; k++) send(cmds[k], $urandom);
      checks++;
      if (occupancy !== 4'd8 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_state: got occ %0d rdy %b expected 8 0", occupancy, in_ready);
      end
      in_valid = 1'b1; in_cmd = 4'd9; in_addr = 32'hA5A5_A5A5;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || occupancy !== 4'd8) begin
            errors++;
            $display("FAIL full_hold: got rdy %b occ %0d expected 0 8", in_ready, occupancy);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL no_pop_through: got rdy %b expected 0", in_ready);
      end
      for (int t = 0; t < 20; t++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (in_ready === 1'b1) begin ok = 1; break; end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ninth_accept: got rdy %b expected 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_drain();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) send(legal_cmds[$urandom_range(0, 8)], $urandom);
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         send(legal_cmds[$urandom_range(0, 8)], $urandom);
         checks++;
         if (occupancy !== 4'd3) begin
            errors++;
            $display("FAIL b2b_occ: got %0d expected 3 at step %0d", occupancy, k);
         end
      end
      wait_drain();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) send(legal_cmds[k], $urandom);
      checks++;
      if (occupancy !== 4'd5) begin
         errors++;
         $display("FAIL mid_fill: got occ %0d expected 5", occupancy);
      end
      rst_n = 1'b0;
      sb.delete();
      #1;
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 4'd0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got vld %b occ %0d rdy %b expected 0 0 0", out_valid, occupancy, in_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_release: got rdy %b vld %b expected 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_stats();
      rst_n = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) send(4'd0, $urandom);
      for (int k = 0; k < 2; k++) send(4'd6, $urandom);
      send(4'd8, $urandom);
      wait_drain();
      checks++;
      if (stat_cpu_reqs !== EXP_CPU || stat_snoop_reqs !== EXP_SNOOP) begin
         errors++;
         $display("FAIL stats: got cpu %0d snoop %0d expected %0d %0d",
                  stat_cpu_reqs, stat_snoop_reqs, EXP_CPU, EXP_SNOOP);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_illegal();
      test_full();
      test_back_to_back();
      test_reset_mid();
      test_stats();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
